// File: rtl/serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_ctrl_pkg
//  Brief    : Shared FSM state type and operation encodings for serial_add_ctrl
//  Revision : 1.0
// ============================================================================
package serial_add_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_ctrl_if
//  Brief    : Request/result bundle between the sequencer front end and the
//             bit-serial add/subtract controller
//  Revision : 1.0
// ============================================================================
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, op, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, op, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_add_ctrl_full.sv
`default_nettype none
// ============================================================================
//  Module   : full
//  Brief    : Combinational one-bit full-adder cell
//  Revision : 1.0
// ============================================================================
module full (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      sum,
    output logic      carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_ctrl
//  Brief    : Bit-serial add/subtract controller, one bit per clock, LSB first,
//             sharing a single full-adder cell across the operand width
//  Revision : 1.0
// ============================================================================
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    serial_add_ctrl_if.slave bus
);
    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;
    logic               w_cell_sum;
    logic               w_cell_carry;

    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_sr;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_done;

    full u_cell (
        .a     (r_sa[0]),
        .b     (r_sb[0]),
        .cin   (r_carry),
        .sum   (w_cell_sum),
        .carry (w_cell_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt == c_last) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_sr    <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                // Subtract is a + ~b + 1: invert B and force the initial carry.
                r_sa    <= bus.a;
                r_sb    <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
                r_carry <= (bus.op == OP_SUB) ? 1'b1 : bus.cin;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_sa    <= r_sa >> 1;
                r_sb    <= r_sb >> 1;
                r_sr    <= {w_cell_sum, r_sr[WIDTH-1:1]};
                r_carry <= w_cell_carry;
                if (!w_last) begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end
            // On the last bit r_carry is the carry into the MSB.
            if (w_last) begin
                r_sum  <= {w_cell_sum, r_sr[WIDTH-1:1]};
                r_cout <= w_cell_carry;
                r_ovf  <= r_carry ^ w_cell_carry;
            end
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire
